// File: rtl/image_frame_capture.sv
// Frame sink: captures one IMG_W x IMG_H pixel frame into on-chip RAM, then serves random-access reads.
// Optional CAPTURE_CHECKSUM_EN adds a 16-bit running sum of stored pixels on port checksum.
module image_frame_capture #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned PIX_W = 8,
  localparam int unsigned NPIX   = IMG_W * IMG_H,
  localparam int unsigned ADDR_W = $clog2(NPIX),
  localparam int unsigned CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              done,
  output logic [CNT_W-1:0]  pix_count,
  output logic              overflow,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_busy;
  logic             r_done;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_pix_count;
  logic             r_overflow;
  logic [PIX_W-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [PIX_W-1:0] r_mem [NPIX];

  logic w_armable;
  logic w_arm;
  logic w_capture_wr;
  logic w_last_wr;
  logic w_rd_ok;

  always_comb begin
    w_armable    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    w_arm        = w_armable && start;
    w_capture_wr = (r_state == ST_CAPTURE) && pix_valid;
    w_last_wr    = w_capture_wr && (r_pix_count == CNT_W'(NPIX - 1));
    w_rd_ok      = (r_state == ST_DONE) && rd_en && (CNT_W'(rd_addr) < CNT_W'(NPIX));
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next_state = ST_CAPTURE;
      ST_CAPTURE: if (w_last_wr) w_next_state = ST_DONE;
      ST_DONE:    if (start) w_next_state = ST_CAPTURE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Status outputs; a stray pixel on the arming cycle still flags overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pix_count  <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_busy       <= (w_next_state == ST_CAPTURE);
      r_done       <= (w_next_state == ST_DONE);
      r_frame_done <= w_last_wr;
      if (w_arm) begin
        r_pix_count <= '0;
      end else if (w_capture_wr) begin
        r_pix_count <= r_pix_count + CNT_W'(1);
      end
      if (w_armable && pix_valid) begin
        r_overflow <= 1'b1;
      end else if (w_arm) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Frame RAM write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk) begin
    if (w_capture_wr) begin
      r_mem[r_pix_count[ADDR_W-1:0]] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rd_data <= r_mem[rd_addr];
      end
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_arm) begin
      r_checksum <= '0;
    end else if (w_capture_wr) begin
      r_checksum <= r_checksum + 16'(pix_in);
    end
  end

  assign checksum = r_checksum;
`endif

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign done       = r_done;
  assign pix_count  = r_pix_count;
  assign overflow   = r_overflow;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_image_frame_capture.sv
// Directed bench for image_frame_capture at default 128x128x8 geometry.
// Define CAPTURE_CHECKSUM_EN for both files to exercise the checksum port.
module tb_image_frame_capture;

  localparam int unsigned NPIX = 16384;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        busy;
  logic        frame_done;
  logic        done;
  logic [14:0] pix_count;
  logic        overflow;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
`ifdef CAPTURE_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_vec;
  int n_err;

  image_frame_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .done       (done),
    .pix_count  (pix_count),
    .overflow   (overflow),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
`ifdef CAPTURE_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pix_in = '0; pix_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;
    #12;
    n_vec++; if ({busy, frame_done, done, overflow, rd_valid} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=00000", {busy, frame_done, done, overflow, rd_valid}); end
    n_vec++; if (pix_count !== 15'd0) begin n_err++; $display("FAIL reset_pix_count got=%0d exp=0", pix_count); end
    n_vec++; if (rd_data !== 8'd0) begin n_err++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture_contiguous();
    int fd_cnt = 0;
    int fd_at = -1;
    pulse_start();
    n_vec++; if (busy !== 1'b1 || pix_count !== 15'd0) begin n_err++; $display("FAIL cap_enter got busy=%b cnt=%0d exp busy=1 cnt=0", busy, pix_count); end
    for (int i = 0; i < NPIX; i++) begin
      pix_valid = 1'b1;
      pix_in = 8'(i % 256);
      tick();
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = i; end
      if (i == 9) begin
        n_vec++; if (pix_count !== 15'd10 || done !== 1'b0) begin n_err++; $display("FAIL cap_mid got cnt=%0d done=%b exp cnt=10 done=0", pix_count, done); end
      end
    end
    pix_valid = 1'b0;
    n_vec++; if (fd_cnt != 1 || fd_at != NPIX - 1) begin n_err++; $display("FAIL cap_frame_done got pulses=%0d at=%0d exp pulses=1 at=%0d", fd_cnt, fd_at, NPIX - 1); end
    n_vec++; if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL cap_status got done=%b busy=%b ovf=%b exp 1 0 0", done, busy, overflow); end
    n_vec++; if (pix_count !== 15'd16384) begin n_err++; $display("FAIL cap_count got=%0d exp=16384", pix_count); end
    tick();
    n_vec++; if (frame_done !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL cap_pulse_width got fd=%b done=%b exp fd=0 done=1", frame_done, done); end
  endtask

  task automatic test_back_to_back_reads();
    logic [13:0] addrs [4] = '{14'd0, 14'd1, 14'd255, 14'd16383};
    logic [7:0]  exps  [4] = '{8'd0, 8'd1, 8'd255, 8'd255};
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      rd_addr = addrs[k];
      tick();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== exps[k]) begin n_err++; $display("FAIL rd_b2b[%0d] got v=%b d=%0d exp v=1 d=%0d", k, rd_valid, rd_data, exps[k]); end
    end
    rd_en = 1'b0;
    tick();
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'd255) begin n_err++; $display("FAIL rd_idle got v=%b d=%0d exp v=0 d=255", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    pix_valid = 1'b1;
    pix_in = 8'hAA;
    tick();
    pix_valid = 1'b0;
    n_vec++; if (overflow !== 1'b1 || done !== 1'b1 || pix_count !== 15'd16384) begin n_err++; $display("FAIL ovf_set got ovf=%b done=%b cnt=%0d exp 1 1 16384", overflow, done, pix_count); end
    rd_en = 1'b1;
    rd_addr = 14'd0;
    tick();
    rd_en = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'd0) begin n_err++; $display("FAIL ovf_ram0 got v=%b d=%0h exp v=1 d=0", rd_valid, rd_data); end
    tick();
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    pulse_start();
    n_vec++; if (overflow !== 1'b0 || pix_count !== 15'd0 || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL ovf_clear got ovf=%b cnt=%0d busy=%b done=%b exp 0 0 1 0", overflow, pix_count, busy, done); end
  endtask

  // Continues the capture armed by test_overflow, using pattern ~(k%256)
  task automatic test_gapped_capture();
    int fd_cnt = 0;
    int fd_at = -1;
    logic [13:0] addrs [5] = '{14'd0, 14'd1, 14'd255, 14'd16383, 14'd100};
    logic [7:0]  exps  [5] = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h9B};
    for (int i = 0; i < 2 * NPIX; i++) begin
      pix_valid = (i % 2 == 0);
      pix_in = (i % 2 == 0) ? ~8'((i / 2) % 256) : 8'h5A;
      rd_en = (i == 20);
      rd_addr = 14'd5;
      if (i == 2 * NPIX - 2) begin
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL gap_early_done got=%b exp=0", done); end
      end
      tick();
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = i; end
      if (i == 11) begin
        n_vec++; if (pix_count !== 15'd6) begin n_err++; $display("FAIL gap_count got=%0d exp=6", pix_count); end
      end
      if (i == 20) begin
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'd0) begin n_err++; $display("FAIL gap_rd_in_capture got v=%b d=%0h exp v=0 d=0", rd_valid, rd_data); end
      end
    end
    pix_valid = 1'b0;
    rd_en = 1'b0;
    n_vec++; if (fd_cnt != 1 || fd_at != 2 * NPIX - 2) begin n_err++; $display("FAIL gap_frame_done got pulses=%0d at=%0d exp pulses=1 at=%0d", fd_cnt, fd_at, 2 * NPIX - 2); end
    n_vec++; if (done !== 1'b1 || pix_count !== 15'd16384) begin n_err++; $display("FAIL gap_status got done=%b cnt=%0d exp 1 16384", done, pix_count); end
    for (int k = 0; k < 5; k++) begin
      rd_en = 1'b1;
      rd_addr = addrs[k];
      tick();
      n_vec++; if (rd_valid !== 1'b1 || rd_data !== exps[k]) begin n_err++; $display("FAIL gap_rd[%0d] got v=%b d=%0h exp v=1 d=%0h", k, rd_valid, rd_data, exps[k]); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    int fd_cnt = 0;
    int fd_at = -1;
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      pix_valid = 1'b1;
      pix_in = 8'h55;
      tick();
    end
    pix_valid = 1'b0;
    n_vec++; if (pix_count !== 15'd100 || busy !== 1'b1) begin n_err++; $display("FAIL rst_pre got cnt=%0d busy=%b exp 100 1", pix_count, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, frame_done, done, overflow, rd_valid} !== 5'b0 || pix_count !== 15'd0 || rd_data !== 8'd0) begin n_err++; $display("FAIL rst_async got flags=%b cnt=%0d d=%0h exp 00000 0 0", {busy, frame_done, done, overflow, rd_valid}, pix_count, rd_data); end
    #3;
    rst_n = 1'b1;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle got busy=%b exp=0", busy); end
    pulse_start();
    for (int i = 0; i < NPIX; i++) begin
      pix_valid = 1'b1;
      pix_in = 8'hFF;
      tick();
      if (frame_done === 1'b1) begin fd_cnt++; fd_at = i; end
    end
    pix_valid = 1'b0;
    n_vec++; if (fd_cnt != 1 || fd_at != NPIX - 1 || pix_count !== 15'd16384) begin n_err++; $display("FAIL rst_recapture got pulses=%0d at=%0d cnt=%0d exp 1 %0d 16384", fd_cnt, fd_at, pix_count, NPIX - 1); end
`ifdef CAPTURE_CHECKSUM_EN
    n_vec++; if (checksum !== 16'hC000) begin n_err++; $display("FAIL checksum got=%0h exp=c000", checksum); end
`endif
    rd_en = 1'b1;
    rd_addr = 14'd0;
    tick();
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin n_err++; $display("FAIL rst_rd0 got v=%b d=%0h exp v=1 d=ff", rd_valid, rd_data); end
    rd_addr = 14'd100;
    tick();
    rd_en = 1'b0;
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin n_err++; $display("FAIL rst_rd100 got v=%b d=%0h exp v=1 d=ff", rd_valid, rd_data); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_capture_contiguous();
    test_back_to_back_reads();
    test_overflow();
    test_gapped_capture();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
